// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the IF-stage hazard/sequencing controller.
package pipeline_ctrl_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int RADDR_W_DEF = 5;
    localparam int CNT_W_DEF   = 16;

    // x0 is hardwired zero, so a load into it can never create a hazard
    localparam logic [RADDR_W_DEF-1:0] X0 = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter used for the stall and flush performance counters.
module hazard_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count one event per cycle, sticking at all-ones instead of wrapping
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// IF-stage sequencer: imem handshake, load-use stalls, branch redirects
// (including redirects that land while a fetch is still outstanding).
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               imem_req_o,
    input  logic               imem_ack_i,
    input  logic [RADDR_W-1:0] if_id_rs1_i,
    input  logic [RADDR_W-1:0] if_id_rs2_i,
    input  logic               if_id_rs1_use_i,
    input  logic               if_id_rs2_use_i,
    input  logic [RADDR_W-1:0] id_ex_rd_i,
    input  logic               id_ex_mem_read_i,
    input  logic               branch_taken_i,
    input  logic [XLEN-1:0]    branch_target_i,
    output logic               pc_en_o,
    output logic               pc_sel_o,
    output logic [XLEN-1:0]    redirect_pc_o,
    output logic               if_id_en_o,
    output logic               if_id_flush_o,
    output logic               id_ex_flush_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o
);

    state_e          state;
    logic [XLEN-1:0] target_q;
    logic            luh;
    logic            stall_inc;
    logic            flush_inc;

    // Load in EX whose rd feeds a source register the ID instruction actually reads
    assign luh = id_ex_mem_read_i && (id_ex_rd_i != RADDR_W'(X0)) &&
                 (((id_ex_rd_i == if_id_rs1_i) && if_id_rs1_use_i) ||
                  ((id_ex_rd_i == if_id_rs2_i) && if_id_rs2_use_i));

    // State and latched redirect target; the target is held while the stale fetch drains
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= IDLE;
            target_q <= '0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (branch_taken_i && !imem_ack_i) begin
                        target_q <= branch_target_i;
                        state    <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (imem_ack_i) state <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode; branch beats load-use, which beats a plain ack
    always_comb begin
        imem_req_o    = 1'b0;
        pc_en_o       = 1'b0;
        pc_sel_o      = 1'b0;
        if_id_en_o    = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        flush_inc     = 1'b0;
        case (state)
            FETCH: begin
                imem_req_o = 1'b1;
                if (branch_taken_i) begin
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                    flush_inc     = 1'b1;
                    if (imem_ack_i) begin
                        pc_en_o  = 1'b1;
                        pc_sel_o = 1'b1;
                    end
                end else if (luh) begin
                    // hold PC and IF/ID; any acked word is dropped and refetched
                    id_ex_flush_o = 1'b1;
                end else if (imem_ack_i) begin
                    pc_en_o    = 1'b1;
                    if_id_en_o = 1'b1;
                end else begin
                    if_id_flush_o = 1'b1;
                end
            end
            DISCARD: begin
                // EX holds a bubble here, so branch_taken_i cannot be genuine
                imem_req_o    = 1'b1;
                if_id_flush_o = 1'b1;
                if (imem_ack_i) begin
                    pc_en_o  = 1'b1;
                    pc_sel_o = 1'b1;
                end
            end
            default: begin
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end
        endcase
    end

    assign redirect_pc_o = (state == DISCARD) ? target_q : branch_target_i;
    assign stall_inc     = (state != IDLE) && !pc_en_o;

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (stall_inc),
        .cnt_o   (stall_cnt_o)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (flush_inc),
        .cnt_o   (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a narrow-counter twin checks saturation.
module tb_pipeline_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        imem_ack_i;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1_use, rs2_use, mem_read;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic        imem_req, pc_en, pc_sel, if_id_en, if_id_flush, id_ex_flush;
    logic [31:0] redirect_pc;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_req, s_pc_en, s_pc_sel, s_if_id_en, s_if_id_flush, s_id_ex_flush;
    logic [31:0] s_redirect;
    logic [2:0]  s_stall, s_flush;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    pipeline_hazard_ctrl dut (
        .clk_i(clk_i), .reset_i(reset_i), .imem_req_o(imem_req), .imem_ack_i(imem_ack_i),
        .if_id_rs1_i(rs1), .if_id_rs2_i(rs2), .if_id_rs1_use_i(rs1_use), .if_id_rs2_use_i(rs2_use),
        .id_ex_rd_i(rd), .id_ex_mem_read_i(mem_read), .branch_taken_i(branch_taken),
        .branch_target_i(branch_target), .pc_en_o(pc_en), .pc_sel_o(pc_sel),
        .redirect_pc_o(redirect_pc), .if_id_en_o(if_id_en), .if_id_flush_o(if_id_flush),
        .id_ex_flush_o(id_ex_flush), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(3)) dut_sat (
        .clk_i(clk_i), .reset_i(reset_i), .imem_req_o(s_req), .imem_ack_i(imem_ack_i),
        .if_id_rs1_i(rs1), .if_id_rs2_i(rs2), .if_id_rs1_use_i(rs1_use), .if_id_rs2_use_i(rs2_use),
        .id_ex_rd_i(rd), .id_ex_mem_read_i(mem_read), .branch_taken_i(branch_taken),
        .branch_target_i(branch_target), .pc_en_o(s_pc_en), .pc_sel_o(s_pc_sel),
        .redirect_pc_o(s_redirect), .if_id_en_o(s_if_id_en), .if_id_flush_o(s_if_id_flush),
        .id_ex_flush_o(s_id_ex_flush), .stall_cnt_o(s_stall), .flush_cnt_o(s_flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pack the six control outputs: {req, pc_en, pc_sel, if_id_en, if_id_flush, id_ex_flush}
    function automatic logic [31:0] ctl();
        return {26'd0, imem_req, pc_en, pc_sel, if_id_en, if_id_flush, id_ex_flush};
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i = 1'b1; imem_ack_i = 1'b1;
        rs1 = 0; rs2 = 0; rd = 0; rs1_use = 0; rs2_use = 0; mem_read = 0;
        branch_taken = 0; branch_target = 32'h0;

        // 1: reset, then release with ack tied high
        @(negedge clk_i);
        chk("reset_ctl", ctl(), 32'b000011);
        chk("reset_stall", 32'(stall_cnt), 0);
        cyc(); reset_i = 1'b0;
        @(negedge clk_i);
        chk("idle_ctl", ctl(), 32'b000011);
        cyc();
        @(negedge clk_i);
        chk("fetch_ack_ctl", ctl(), 32'b110100);
        chk("fetch_stall0", 32'(stall_cnt), 0);

        // 2: load-use on rs1
        cyc(); mem_read = 1; rd = 5; rs1 = 5; rs1_use = 1;
        @(negedge clk_i);
        chk("luh_ctl", ctl(), 32'b100001);
        cyc(); mem_read = 0;
        @(negedge clk_i);
        chk("luh_stall_cnt", 32'(stall_cnt), 1);
        chk("after_luh_ctl", ctl(), 32'b110100);

        // 3: rd=x0 never stalls; unused rs2 never stalls
        cyc(); mem_read = 1; rd = 0; rs1 = 0; rs1_use = 1;
        @(negedge clk_i);
        chk("luh_x0_ctl", ctl(), 32'b110100);
        cyc(); rd = 5; rs1 = 3; rs1_use = 1; rs2 = 5; rs2_use = 0;
        @(negedge clk_i);
        chk("luh_rs2_unused_ctl", ctl(), 32'b110100);
        cyc(); rs2_use = 1;
        @(negedge clk_i);
        chk("luh_rs2_ctl", ctl(), 32'b100001);
        cyc(); mem_read = 0; rs2_use = 0; rs1_use = 0;
        @(negedge clk_i);
        chk("luh3_stall_cnt", 32'(stall_cnt), 2);

        // 4: branch with ack
        cyc(); branch_taken = 1; branch_target = 32'h100;
        @(negedge clk_i);
        chk("br_ack_ctl", ctl(), 32'b111011);
        chk("br_ack_redirect", redirect_pc, 32'h100);
        cyc(); branch_taken = 0;
        @(negedge clk_i);
        chk("br_ack_flush_cnt", 32'(flush_cnt), 1);
        chk("br_ack_stall_cnt", 32'(stall_cnt), 2);

        // 5: branch without ack, three DISCARD wait cycles, then ack
        cyc(); branch_taken = 1; branch_target = 32'h200; imem_ack_i = 0;
        @(negedge clk_i);
        chk("br_noack_ctl", ctl(), 32'b100011);
        cyc(); branch_taken = 0; branch_target = 32'h999;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("discard_wait_ctl", ctl(), 32'b100010);
            chk("discard_redirect", redirect_pc, 32'h200);
            cyc();
        end
        imem_ack_i = 1;
        @(negedge clk_i);
        chk("discard_ack_ctl", ctl(), 32'b111010);
        chk("discard_ack_redirect", redirect_pc, 32'h200);
        chk("discard_stall_cnt", 32'(stall_cnt), 6);
        chk("discard_flush_cnt", 32'(flush_cnt), 2);
        cyc();
        @(negedge clk_i);
        chk("refetch_ctl", ctl(), 32'b110100);
        chk("refetch_redirect", redirect_pc, 32'h999);

        // 6: branch beats load-use
        cyc(); branch_taken = 1; branch_target = 32'h300; mem_read = 1; rd = 7; rs1 = 7; rs1_use = 1;
        @(negedge clk_i);
        chk("br_luh_ctl", ctl(), 32'b111011);
        cyc(); branch_taken = 0; mem_read = 0;
        @(negedge clk_i);
        chk("br_luh_flush_cnt", 32'(flush_cnt), 3);
        chk("br_luh_stall_cnt", 32'(stall_cnt), 6);

        // async reset while in DISCARD
        cyc(); branch_taken = 1; branch_target = 32'h400; imem_ack_i = 0;
        cyc(); branch_taken = 0; branch_target = 32'h44;
        @(negedge clk_i);
        chk("pre_reset_discard_ctl", ctl(), 32'b100010);
        #1 reset_i = 1'b1;
        #1;
        chk("midreset_ctl", ctl(), 32'b000011);
        chk("midreset_redirect", redirect_pc, 32'h44);
        chk("midreset_stall", 32'(stall_cnt), 0);
        chk("midreset_flush", 32'(flush_cnt), 0);

        // saturation: ten stalled FETCH cycles on a 3-bit counter
        cyc(); reset_i = 1'b0;
        cyc();
        repeat (10) cyc();
        @(negedge clk_i);
        chk("noack_ctl", ctl(), 32'b100010);
        chk("wide_stall_cnt", 32'(stall_cnt), 10);
        chk("sat_stall_cnt", 32'(s_stall), 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
